// File: rtl/funct_generator_dac_reader.sv
// Sample-FIFO consumer: pops signed fixed-point samples, converts them to offset-binary
// DAC codes and shifts each code MSB-first over a mode-0 serial DAC link.
module funct_generator_dac_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INT_BITS   = 4,
  parameter int unsigned DAC_BITS   = 16,
  parameter int unsigned SCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  rd_en_o,
  output logic                  sclk_o,
  output logic                  cs_n_o,
  output logic                  mosi_o,
  output logic                  busy_o,
  output logic                  underrun_o
);

  localparam int unsigned DW = $clog2(SCLK_DIV + 1);
  localparam int unsigned BW = $clog2(DAC_BITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST = DW'((SCLK_DIV > 1) ? (SCLK_DIV - 2) : 0);
  localparam logic [BW-1:0] BIT_LAST = BW'(DAC_BITS - 1);

  typedef enum logic [2:0] {IDLE, READ, LOAD, SHIFT, GAP} state_t;

  state_t                state, state_d;
  logic [DW-1:0]         div_cnt, div_cnt_d;
  logic [BW-1:0]         bit_cnt, bit_cnt_d;
  logic [DAC_BITS-1:0]   sreg, sreg_d, code;
  logic                  frame_done, frame_done_d;
  logic                  rd_en_d, sclk_d, cs_n_d, mosi_d, busy_d, underrun_d;
  logic                  unused_ok;

  assign code = {~data_i[DATA_WIDTH-1], data_i[DATA_WIDTH-2 -: DAC_BITS-1]};

  // Low-order sample bits and the integer-bit count do not affect the DAC code.
  assign unused_ok = &{1'b0, data_i, 1'(INT_BITS)};

  always_comb begin
    state_d      = state;
    div_cnt_d    = div_cnt;
    bit_cnt_d    = bit_cnt;
    sreg_d       = sreg;
    frame_done_d = frame_done;
    sclk_d       = sclk_o;
    cs_n_d       = cs_n_o;
    mosi_d       = mosi_o;
    underrun_d   = underrun_o;

    case (state)
      IDLE: begin
        if (en_i && !empty_i) state_d = READ;
      end
      READ: state_d = LOAD;
      LOAD: begin
        sreg_d    = code;
        mosi_d    = code[DAC_BITS-1];
        cs_n_d    = 1'b0;
        sclk_d    = 1'b0;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_o) begin
            sclk_d = 1'b1;
          end else if (bit_cnt == BIT_LAST) begin
            sclk_d       = 1'b0;
            cs_n_d       = 1'b1;
            mosi_d       = 1'b0;
            frame_done_d = 1'b1;
            // The IDLE cycle is the last cycle of the chip-select gap, so GAP itself
            // lasts SCLK_DIV-1 cycles and is skipped entirely when SCLK_DIV is 1.
            state_d      = (SCLK_DIV > 1) ? GAP : IDLE;
          end else begin
            sclk_d    = 1'b0;
            sreg_d    = {sreg[DAC_BITS-2:0], 1'b0};
            mosi_d    = sreg[DAC_BITS-2];
            bit_cnt_d = bit_cnt + BW'(1);
          end
        end else begin
          div_cnt_d = div_cnt + DW'(1);
        end
      end
      GAP: begin
        if (div_cnt == GAP_LAST) state_d = IDLE;
        else                     div_cnt_d = div_cnt + DW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (!en_i) begin
      frame_done_d = 1'b0;
      underrun_d   = 1'b0;
    end else if (state == IDLE && empty_i && frame_done) begin
      underrun_d = 1'b1;
    end

    rd_en_d = (state_d == READ);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sreg       <= '0;
      frame_done <= 1'b0;
      rd_en_o    <= 1'b0;
      sclk_o     <= 1'b0;
      cs_n_o     <= 1'b1;
      mosi_o     <= 1'b0;
      busy_o     <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      state      <= state_d;
      div_cnt    <= div_cnt_d;
      bit_cnt    <= bit_cnt_d;
      sreg       <= sreg_d;
      frame_done <= frame_done_d;
      rd_en_o    <= rd_en_d;
      sclk_o     <= sclk_d;
      cs_n_o     <= cs_n_d;
      mosi_o     <= mosi_d;
      busy_o     <= busy_d;
      underrun_o <= underrun_d;
    end
  end

endmodule
